// File: rtl/multiplier_pipe.sv
// -----------------------------------------------------------------------------
// multiplier_pipe
//
// Pipelined signed/unsigned integer multiplier with valid/ready handshakes and
// a sideband tag. Each operand carries its own signedness flag. The product is
// the low 2*DATA_WIDTH bits of the exact product of the (DATA_WIDTH+1)-bit
// sign- or zero-extended operands.
//
// The multiplier bits of B are split into PIPE_STAGES contiguous chunks. Stage
// k adds the partial products for chunk k into a running accumulator, so the
// partial-product generation and reduction are spread evenly over the pipe.
// With PIPE_STAGES=1 this collapses to a single registered multiply.
//
// All stages advance together whenever in_ready is high (global stall).
// Bubbles travel through the pipe and are not collapsed.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     input operation present
//   in_ready     block accepts the input this cycle
//   in_a, in_b   operands (DATA_WIDTH bits)
//   in_a_signed  A is two's complement when 1, unsigned when 0
//   in_b_signed  B is two's complement when 1, unsigned when 0
//   in_tag       sideband tag carried with the operation
//   out_valid    result present
//   out_ready    downstream accepts the result
//   out_p        product (2*DATA_WIDTH bits)
//   out_signed   in_a_signed | in_b_signed of that operation
//   out_tag      tag of that operation
// -----------------------------------------------------------------------------
module multiplier_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    in_a_signed,
  input  logic                    in_b_signed,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_p,
  output logic                    out_signed,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int PW    = 2 * DATA_WIDTH;   // product width
  localparam int BW    = DATA_WIDTH + 1;   // extended multiplier width
  localparam int CHUNK = (BW + PIPE_STAGES - 1) / PIPE_STAGES;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic                 is_signed;
    logic [PW-1:0]        a;     // multiplicand, extended to product width
    logic [BW-1:0]        b;     // multiplier as a BW-bit two's complement value
    logic [PW-1:0]        acc;   // partial sum of the chunks handled so far
  } stage_t;

  stage_t stage_q [PIPE_STAGES];
  stage_t stage_d [PIPE_STAGES];

  // Sum of the partial products for the multiplier bits owned by stage k.
  // b is a BW-bit two's complement number, so its top bit weighs -2^(BW-1);
  // a zero-extended multiplier simply has that bit clear. Working modulo
  // 2^PW keeps the low product bits exact for every sign combination.
  function automatic logic [PW-1:0] partial_sum(input logic [PW-1:0] a,
                                                input logic [BW-1:0] b,
                                                input int            k);
    logic [PW-1:0] sum;
    sum = '0;
    for (int j = 0; j < BW; j++) begin
      if ((j / CHUNK) == k && b[j]) begin
        if (j == BW - 1) sum = sum - (a << j);
        else             sum = sum + (a << j);
      end
    end
    return sum;
  endfunction

  // Only out_ready reaches in_ready combinationally; out_valid is a register.
  assign out_valid  = stage_q[PIPE_STAGES-1].valid;
  assign out_p      = stage_q[PIPE_STAGES-1].acc;
  assign out_signed = stage_q[PIPE_STAGES-1].is_signed;
  assign out_tag    = stage_q[PIPE_STAGES-1].tag;
  assign in_ready   = !rst && (!out_valid || out_ready);

  // NOTE: combinational logic uses blocking assignments and gives every
  // variable a value on every pass (src is cleared first), so no latch forms.
  always_comb begin
    for (int k = 0; k < PIPE_STAGES; k++) begin
      stage_t src;
      src = '0;
      if (k == 0) begin
        // A bubble enters with all-zero data so idle inputs never leak through.
        if (in_valid) begin
          src.valid     = 1'b1;
          src.tag       = in_tag;
          src.is_signed = in_a_signed | in_b_signed;
          src.a         = {{DATA_WIDTH{in_a_signed & in_a[DATA_WIDTH-1]}}, in_a};
          src.b         = {in_b_signed & in_b[DATA_WIDTH-1], in_b};
        end
      end else begin
        src = stage_q[k-1];
      end
      stage_d[k]     = src;
      stage_d[k].acc = src.acc + partial_sum(src.a, src.b, k);
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage array is cleared on reset (not just the valid bits)
      // because the last stage drives out_p/out_tag/out_signed directly.
      for (int k = 0; k < PIPE_STAGES; k++) stage_q[k] <= '0;
    end else if (in_ready) begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_multiplier_pipe.sv
// -----------------------------------------------------------------------------
// tb_multiplier_pipe
//
// Self-checking bench for multiplier_pipe. Four instances with
// (DATA_WIDTH, PIPE_STAGES) = (8,3), (16,1), (32,5), (64,8) run the same
// sequence in parallel: reset state, directed sign cases with latency check,
// a 20-op stream under random backpressure against a scoreboard fed by an
// independent golden model, and a mid-operation reset.
// -----------------------------------------------------------------------------
module tb_multiplier_pipe;

  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : 64;
    localparam int S = (g == 0) ? 3 : (g == 1) ? 1  : (g == 2) ? 5  : 8;

    logic           rst, in_valid, in_ready, in_a_signed, in_b_signed;
    logic           out_valid, out_ready, out_signed;
    logic [W-1:0]   in_a, in_b;
    logic [TW-1:0]  in_tag, out_tag;
    logic [2*W-1:0] out_p;
    bit             done = 1'b0;
    string          pfx;

    multiplier_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(S), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .out_signed(out_signed), .out_tag(out_tag)
    );

    typedef struct {
      logic [2*W-1:0] p;
      logic           s;
      logic [TW-1:0]  tag;
    } exp_t;

    exp_t sb[$];

    // Golden model: exact signed product of the extended operands.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic as, input logic bs);
      logic signed [W:0]     ae, be;
      logic signed [2*W+1:0] pr;
      ae = as ? $signed({a[W-1], a}) : $signed({1'b0, a});
      be = bs ? $signed({b[W-1], b}) : $signed({1'b0, b});
      pr = (2*W+2)'(ae) * (2*W+2)'(be);
      return pr[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
    endfunction

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic as, input logic bs,
                            input logic [TW-1:0] t);
      in_valid = 1'b1; in_a = a; in_b = b;
      in_a_signed = as; in_b_signed = bs; in_tag = t;
    endtask

    // Garbage on the data inputs while idle must have no effect.
    task automatic idle();
      in_valid = 1'b0; in_a = rnd(); in_b = rnd();
      in_a_signed = 1'($urandom_range(0, 1));
      in_b_signed = 1'($urandom_range(0, 1));
      in_tag = TW'($urandom());
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic as, input logic bs,
                            input logic [TW-1:0] t);
      int lat;
      @(negedge clk);
      drive_op(a, b, as, bs, t);
      out_ready = 1'b1;
      #1 check({pfx, "dir_in_ready"}, in_ready, 1);
      @(negedge clk);
      idle();
      #1;
      lat = 1;
      while (!out_valid && lat < S + 4) begin
        @(negedge clk);
        #1;
        lat++;
      end
      check({pfx, "dir_latency"}, lat, S);
      check({pfx, "dir_p"}, out_p, model(a, b, as, bs));
      check({pfx, "dir_signed"}, out_signed, as | bs);
      check({pfx, "dir_tag"}, out_tag, t);
      @(negedge clk);
      #1 check({pfx, "dir_no_dup"}, out_valid, 0);
    endtask

    task automatic stream();
      int             acc_n, del_n, cyc;
      logic           held_v;
      logic [2*W-1:0] hp;
      logic           hs;
      logic [TW-1:0]  ht;
      exp_t           e;
      acc_n = 0; del_n = 0; cyc = 0; held_v = 1'b0;
      hp = '0; hs = 1'b0; ht = '0;
      while (del_n < 20 && cyc < 600) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        if (acc_n < 20)
          drive_op(rnd(), rnd(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), TW'(acc_n));
        else
          idle();
        #1;
        if (held_v) begin
          check({pfx, "stall_valid"}, out_valid, 1);
          check({pfx, "stall_p"}, out_p, hp);
          check({pfx, "stall_signed"}, out_signed, hs);
          check({pfx, "stall_tag"}, out_tag, ht);
        end
        check({pfx, "in_ready_rule"}, in_ready, !(out_valid && !out_ready));
        if (in_valid && in_ready) begin
          e.p   = model(in_a, in_b, in_a_signed, in_b_signed);
          e.s   = in_a_signed | in_b_signed;
          e.tag = in_tag;
          sb.push_back(e);
          acc_n++;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check({pfx, "unexpected_out"}, 1, 0);
          end else begin
            e = sb.pop_front();
            check({pfx, "stream_p"}, out_p, e.p);
            check({pfx, "stream_signed"}, out_signed, e.s);
            check({pfx, "stream_tag"}, out_tag, e.tag);
          end
          del_n++;
        end
        held_v = out_valid && !out_ready;
        hp = out_p; hs = out_signed; ht = out_tag;
        cyc++;
      end
      check({pfx, "stream_count"}, del_n, 20);
      check({pfx, "stream_sb_empty"}, sb.size(), 0);
    endtask

    task automatic reset_mid_op();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        out_ready = 1'b1;
        drive_op(rnd(), rnd(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), TW'(i + 9));
        #1 check({pfx, "mid_accept"}, in_ready, 1);
      end
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1 check({pfx, "mid_rst_in_ready"}, in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check({pfx, "mid_rst_valid"}, out_valid, 0);
      check({pfx, "mid_rst_p"}, out_p, 0);
      check({pfx, "mid_rst_in_ready"}, in_ready, 1);
      for (int i = 0; i < S + 4; i++) begin
        @(negedge clk);
        #1 check({pfx, "no_stale"}, out_valid, 0);
      end
    endtask

    initial begin
      pfx = $sformatf("w%0d_s%0d_", W, S);
      rst = 1'b1;
      out_ready = 1'b0;
      idle();
      @(negedge clk);
      #1 check({pfx, "rst_in_ready"}, in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check({pfx, "post_rst_valid"}, out_valid, 0);
      check({pfx, "post_rst_p"}, out_p, 0);
      check({pfx, "post_rst_tag"}, out_tag, 0);
      check({pfx, "post_rst_signed"}, out_signed, 0);
      check({pfx, "post_rst_in_ready"}, in_ready, 1);

      directed(W'(255), W'(255), 1'b0, 1'b0, 4'd5);
      directed(W'(-128), W'(-128), 1'b1, 1'b1, 4'd1);
      directed(W'(-10), W'(7), 1'b1, 1'b1, 4'd2);
      directed('1, W'(255), 1'b1, 1'b0, 4'd3);
      directed(W'(255), W'(2), 1'b0, 1'b1, 4'd4);
      stream();
      reset_mid_op();
      done = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      if (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) break;
    end
    check("all_configs_done",
          {cfg[3].done, cfg[2].done, cfg[1].done, cfg[0].done}, 4'hf);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Spec-given 8-bit reference points, checked independently of the model.
  initial begin
    logic [15:0] r;
    @(negedge clk);
    r = cfg[0].model(8'd255, 8'd255, 1'b0, 1'b0);
    check("ref_255x255", r, 16'hFE01);
    r = cfg[0].model(8'h80, 8'h80, 1'b1, 1'b1);
    check("ref_m128xm128", r, 16'd16384);
    r = cfg[0].model(8'hF6, 8'd7, 1'b1, 1'b1);
    check("ref_m10x7", r, 16'hFFBA);
    r = cfg[0].model(8'hFF, 8'd255, 1'b1, 1'b0);
    check("ref_m1x255", r, 16'hFF01);
    r = cfg[0].model(8'd255, 8'd2, 1'b0, 1'b1);
    check("ref_255x2", r, 16'd510);
  end

endmodule
